// File: rtl/pulse_det_pkg.sv
// Shared types and helpers for the multi-channel pulse-width detector.
package pulse_det_pkg;

  // Per-channel detector state.
  typedef enum logic [1:0] {
    UNARMED = 2'd0,
    ARMED   = 2'd1,
    ACTIVE  = 2'd2
  } pd_state_t;

  // Clamp a window bound into [floor_v, ceil_v]. Used for both ends of the
  // effective window: lo = clamp(min_w, 1, inf), hi = clamp(max_w, 0, MAX_W).
  function automatic logic [31:0] pd_clamp(input logic [31:0] v,
                                           input logic [31:0] floor_v,
                                           input logic [31:0] ceil_v);
    logic [31:0] r;
    r = v;
    if (r < floor_v) r = floor_v;
    if (r > ceil_v)  r = ceil_v;
    return r;
  endfunction

endpackage

// File: rtl/pulse_width_channel.sv
// One channel of the pulse-width detector: arming FSM, saturating width
// counter, edge strobes and the captured width of the last accepted pulse.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   UNARMED | after reset / polarity change; waiting for one inactive sample
//   ARMED   | inactive seen; next active sample starts a pulse
//   ACTIVE  | pulse in progress; cnt holds samples seen so far (sat MAX_W+1)
module pulse_width_channel
  import pulse_det_pkg::*;
#(
  parameter int MAX_W = 8,
  parameter int CW    = $clog2(MAX_W + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a,
  input  logic          polarity,
  input  logic [CW-1:0] lo,
  input  logic [CW-1:0] hi,
  output logic          rise,
  output logic          fall,
  output logic          pulse_detected,
  output logic          too_long,
  output logic [CW-1:0] pulse_width
);

  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_W + 1);

  pd_state_t     state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          act_prev_q;
  logic          prev_valid_q;
  logic          pol_q;
  logic          tl_done_q;
  logic          rise_q;
  logic          fall_q;
  logic          det_q;
  logic          tl_q;
  logic [CW-1:0] width_q;

  logic          act;
  logic          pol_change;
  logic          in_window;

  // Active level after polarity, saturating increment and window test.
  always_comb begin
    act        = a ^ polarity;
    pol_change = (pol_q != polarity);
    cnt_d      = (cnt_q >= CNT_SAT) ? CNT_SAT : cnt_q + CW'(1);
    in_window  = (cnt_q >= lo) && (cnt_q <= hi);
  end

  // Channel FSM with registered strobes; a polarity change restarts the
  // channel and suppresses every strobe on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= UNARMED;
      cnt_q        <= '0;
      act_prev_q   <= 1'b0;
      prev_valid_q <= 1'b0;
      pol_q        <= 1'b0;
      tl_done_q    <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      det_q        <= 1'b0;
      tl_q         <= 1'b0;
      width_q      <= '0;
    end else if (pol_change) begin
      state_q      <= UNARMED;
      cnt_q        <= '0;
      act_prev_q   <= 1'b0;
      prev_valid_q <= 1'b0;
      pol_q        <= polarity;
      tl_done_q    <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      det_q        <= 1'b0;
      tl_q         <= 1'b0;
    end else begin
      act_prev_q   <= act;
      prev_valid_q <= 1'b1;
      rise_q       <= act & ~act_prev_q & prev_valid_q;
      fall_q       <= ~act & act_prev_q & prev_valid_q;
      det_q        <= 1'b0;
      tl_q         <= 1'b0;
      case (state_q)
        UNARMED: begin
          if (!act) state_q <= ARMED;
        end
        ARMED: begin
          if (act) begin
            state_q   <= ACTIVE;
            cnt_q     <= CW'(1);
            tl_done_q <= 1'b0;
          end
        end
        ACTIVE: begin
          if (act) begin
            cnt_q <= cnt_d;
            // tl_done_q guards against a second report if hi moves mid-pulse.
            if ((cnt_q == hi) && !tl_done_q) begin
              tl_q      <= 1'b1;
              tl_done_q <= 1'b1;
            end
          end else begin
            state_q <= ARMED;
            if (in_window) begin
              det_q   <= 1'b1;
              width_q <= cnt_q;
            end
          end
        end
        default: state_q <= UNARMED;
      endcase
    end
  end

  assign rise           = rise_q;
  assign fall           = fall_q;
  assign pulse_detected = det_q;
  assign too_long       = tl_q;
  assign pulse_width    = width_q;

endmodule

// File: rtl/multi_pulse_width_detector.sv
// N_CH independent glitch-filtering pulse-width detectors sharing one
// run-time acceptance window.
module multi_pulse_width_detector
  import pulse_det_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int MAX_W = 8,
  localparam int CW    = $clog2(MAX_W + 2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH-1:0]    a,
  input  logic [N_CH-1:0]    polarity,
  input  logic [CW-1:0]      min_w,
  input  logic [CW-1:0]      max_w,
  output logic [N_CH-1:0]    rise,
  output logic [N_CH-1:0]    fall,
  output logic [N_CH-1:0]    pulse_detected,
  output logic [N_CH-1:0]    too_long,
  output logic [N_CH*CW-1:0] pulse_width
);

  logic [CW-1:0] lo;
  logic [CW-1:0] hi;

  // Effective window computed once: a zero minimum still needs one sample,
  // and nothing beyond MAX_W can be resolved by the counter.
  always_comb begin
    lo = CW'(pd_clamp(32'(min_w), 32'd1, 32'hFFFF_FFFF));
    hi = CW'(pd_clamp(32'(max_w), 32'd0, 32'(MAX_W)));
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    pulse_width_channel #(
      .MAX_W (MAX_W),
      .CW    (CW)
    ) u_ch (
      .clk            (clk),
      .rst_n          (rst_n),
      .a              (a[gi]),
      .polarity       (polarity[gi]),
      .lo             (lo),
      .hi             (hi),
      .rise           (rise[gi]),
      .fall           (fall[gi]),
      .pulse_detected (pulse_detected[gi]),
      .too_long       (too_long[gi]),
      .pulse_width    (pulse_width[gi*CW +: CW])
    );
  end

endmodule

// File: tb/tb_multi_pulse_width_detector.sv
// Scoreboard bench: the driver pushes the expected output set for each edge
// from a run-length reference model; the monitor pops and compares it.
module tb_multi_pulse_width_detector;

  localparam int N_CH  = 4;
  localparam int MAX_W = 8;
  localparam int CW    = $clog2(MAX_W + 2);

  logic               clk;
  logic               rst_n;
  logic [N_CH-1:0]    a;
  logic [N_CH-1:0]    polarity;
  logic [CW-1:0]      min_w;
  logic [CW-1:0]      max_w;
  logic [N_CH-1:0]    rise;
  logic [N_CH-1:0]    fall;
  logic [N_CH-1:0]    pulse_detected;
  logic [N_CH-1:0]    too_long;
  logic [N_CH*CW-1:0] pulse_width;

  multi_pulse_width_detector #(.N_CH(N_CH), .MAX_W(MAX_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .a              (a),
    .polarity       (polarity),
    .min_w          (min_w),
    .max_w          (max_w),
    .rise           (rise),
    .fall           (fall),
    .pulse_detected (pulse_detected),
    .too_long       (too_long),
    .pulse_width    (pulse_width)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [N_CH-1:0]    rise;
    logic [N_CH-1:0]    fall;
    logic [N_CH-1:0]    det;
    logic [N_CH-1:0]    tl;
    logic [N_CH*CW-1:0] width;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   det_cnt[N_CH];
  int   tl_cnt[N_CH];

  // Reference model: per channel, the polarity it believes is registered,
  // samples seen since the last restart, the last sample, whether any
  // inactive sample has been seen, the current run of active samples.
  bit   m_pol[N_CH];
  int   m_nsamp[N_CH];
  bit   m_prev[N_CH];
  bit   m_seen0[N_CH];
  int   m_run[N_CH];
  bit   m_tl[N_CH];
  int   m_width[N_CH];

  function automatic void model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_pol[i] = 1'b0; m_nsamp[i] = 0; m_prev[i] = 1'b0; m_seen0[i] = 1'b0;
      m_run[i] = 0; m_tl[i] = 1'b0; m_width[i] = 0;
    end
  endfunction

  task automatic model_push();
    exp_t e;
    int   lo, hi, w;
    bit   act;
    e  = '0;
    lo = (int'(min_w) < 1) ? 1 : int'(min_w);
    hi = (int'(max_w) > MAX_W) ? MAX_W : int'(max_w);
    for (int i = 0; i < N_CH; i++) begin
      act = a[i] ^ polarity[i];
      if (polarity[i] != m_pol[i]) begin
        m_pol[i] = polarity[i]; m_nsamp[i] = 0; m_seen0[i] = 1'b0;
        m_run[i] = 0; m_tl[i] = 1'b0;
      end else begin
        if (m_nsamp[i] > 0) begin
          e.rise[i] = act & ~m_prev[i];
          e.fall[i] = ~act & m_prev[i];
        end
        if (act) begin
          m_run[i]++;
          w = (m_run[i] - 1 > MAX_W + 1) ? MAX_W + 1 : m_run[i] - 1;
          if (m_seen0[i] && m_run[i] >= 2 && !m_tl[i] && w == hi) begin
            e.tl[i] = 1'b1;
            m_tl[i] = 1'b1;
          end
        end else begin
          w = (m_run[i] > MAX_W + 1) ? MAX_W + 1 : m_run[i];
          if (m_seen0[i] && m_run[i] > 0 && w >= lo && w <= hi) begin
            e.det[i]   = 1'b1;
            m_width[i] = w;
          end
          m_seen0[i] = 1'b1; m_run[i] = 0; m_tl[i] = 1'b0;
        end
        m_prev[i] = act;
        m_nsamp[i]++;
      end
      e.width[i*CW +: CW] = CW'(m_width[i]);
    end
    sb_q.push_back(e);
  endtask

  // Monitor: one comparison per clock, 1 time unit after the edge.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      got = '{rise: rise, fall: fall, det: pulse_detected, tl: too_long, width: pulse_width};
      if (!rst_n) begin
        n_cmp++;
        if (got != '0) begin
          n_err++;
          $display("FAIL reset_outputs t=%0t: got %h, want 0", $time, got);
        end
      end else if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (got !== e) begin
          n_err++;
          $display("FAIL scoreboard t=%0t: rise %h/%h fall %h/%h det %h/%h tl %h/%h width %h/%h (got/want)",
                   $time, rise, e.rise, fall, e.fall, pulse_detected, e.det,
                   too_long, e.tl, pulse_width, e.width);
        end
        for (int i = 0; i < N_CH; i++) begin
          det_cnt[i] += int'(pulse_detected[i]);
          tl_cnt[i]  += int'(too_long[i]);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, got, want);
    end
  endtask

  task automatic step(input logic [N_CH-1:0] av);
    a = av;
    model_push();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input int ch, input int w);
    logic [N_CH-1:0] v;
    v     = '0;
    v[ch] = 1'b1;
    repeat (w) step(v);
    step('0);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    sb_q.delete();
    #1;
    chk("reset_width", int'(|pulse_width), 0);
    chk("reset_strobes", int'(|{rise, fall, pulse_detected, too_long}), 0);
    repeat (cycles) begin
      @(posedge clk);
      #2;
    end
    rst_n = 1'b1;
  endtask

  function automatic int width_of(input int ch);
    return int'(pulse_width[ch*CW +: CW]);
  endfunction

  int d0, t0, dsum;
  logic [N_CH-1:0] cur;
  int div;

  initial begin
    rst_n    = 1'b0;
    a        = 4'b0010;
    polarity = '0;
    min_w    = CW'(1);
    max_w    = CW'(1);
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // 010 on ch0, ch1 held active across reset release.
    step(4'b0010);
    step(4'b0011);
    step(4'b0010);
    chk("t1_det0", int'(pulse_detected[0]), 1);
    chk("t1_width0", width_of(0), 1);
    step(4'b0000);
    chk("t1_fall1", int'(fall[1]), 1);
    chk("t1_nodet1", int'(pulse_detected[1]), 0);
    chk("t1_det1_total", det_cnt[1], 0);

    // Window 2..3 against widths 1..4.
    min_w = CW'(2);
    max_w = CW'(3);
    step('0);
    t0 = tl_cnt[0];
    pulse(0, 1); chk("t2_w1_rej", int'(pulse_detected[0]), 0); step('0);
    pulse(0, 2); chk("t2_w2_det", int'(pulse_detected[0]), 1); chk("t2_w2_width", width_of(0), 2); step('0);
    pulse(0, 3); chk("t2_w3_det", int'(pulse_detected[0]), 1); chk("t2_w3_width", width_of(0), 3); step('0);
    pulse(0, 4); chk("t2_w4_rej", int'(pulse_detected[0]), 0); chk("t2_w4_width_held", width_of(0), 3);
    chk("t2_w4_too_long", tl_cnt[0] - t0, 1);
    step('0);

    // max_w above MAX_W, 20-cycle pulse saturates.
    min_w = CW'(1);
    max_w = CW'(15);
    d0 = det_cnt[3];
    t0 = tl_cnt[3];
    pulse(3, 20);
    chk("t3_too_long_once", tl_cnt[3] - t0, 1);
    chk("t3_no_det", det_cnt[3] - d0, 0);
    step('0);

    // Low-polarity pulse on ch2, then polarity flip mid-pulse.
    min_w = CW'(2);
    max_w = CW'(2);
    polarity = 4'b0100;
    step(4'b0100);
    step(4'b0100);
    step(4'b0000);
    step(4'b0000);
    step(4'b0100);
    chk("t4_det2", int'(pulse_detected[2]), 1);
    chk("t4_width2", width_of(2), 2);
    step(4'b0000);
    step(4'b0000);
    polarity = 4'b0000;
    step(4'b0000);
    chk("t4_polchg_quiet", int'(rise[2] | fall[2] | pulse_detected[2] | too_long[2]), 0);
    chk("t4_width_hold", width_of(2), 2);
    step(4'b0000);
    step(4'b0100);
    step(4'b0000);

    // All channels at once, then reset mid-pulse.
    min_w = CW'(1);
    max_w = CW'(1);
    step(4'b0000);
    step(4'b1111);
    step(4'b0000);
    chk("t5_all_det", int'(pulse_detected), 15);
    step(4'b1111);
    dsum = det_cnt[0] + det_cnt[1] + det_cnt[2] + det_cnt[3];
    do_reset(3);
    step(4'b1111);
    step(4'b0000);
    step(4'b1111);
    chk("t5_held_no_det", det_cnt[0] + det_cnt[1] + det_cnt[2] + det_cnt[3] - dsum, 0);
    step(4'b0000);

    // Randomised traffic checked purely by the scoreboard.
    cur = '0;
    div = 4;
    for (int n = 0; n < 1500; n++) begin
      if (n % 100 == 0) begin
        case ($urandom_range(2))
          0:       div = 2;
          1:       div = 4;
          default: div = 16;
        endcase
      end
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(div - 1) == 0) cur[i] = ~cur[i];
        if ($urandom_range(63) == 0) polarity[i] = ~polarity[i];
      end
      if ($urandom_range(31) == 0) begin
        min_w = CW'($urandom_range(4));
        max_w = CW'($urandom_range(MAX_W + 6));
      end
      if ($urandom_range(249) == 0) do_reset(2);
      step(cur);
    end

    step('0);
    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_pulse_width_detector.md
# multi_pulse_width_detector

Multi-channel, parametrised pulse detector that generalises the single-channel "010" one-cycle detector. It adds:
- per-channel polarity
- run-time minimum/maximum pulse-width window
- rise/fall edge strobes
- a captured width value and an over-length flag

It sits behind input synchronisers and feeds event logic that needs glitch-filtered pulses of bounded width.

## Interface
- `N_CH`, 4: number of independent channels.
- `MAX_W`, 8: largest width (cycles) the counter resolves; must be ≥ 1.
- `CW`, `$clog2(MAX_W+2)`: counter/width-port width (derived, not overridden).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a`  in  `N_CH`  channel inputs, already synchronous to `clk`.
- `polarity`  in  `N_CH`  0: detect high pulses; 1: detect low pulses (quasi-static).
- `min_w`  in  `CW`  minimum accepted width, shared by all channels.
- `max_w`  in  `CW`  maximum accepted width, shared by all channels.
- `rise`  out  `N_CH`  one-cycle strobe: inactive→active transition.
- `fall`  out  `N_CH`  one-cycle strobe: active→inactive transition.
- `pulse_detected`  out  `N_CH`  one-cycle strobe: pulse ended with width inside window.
- `too_long`  out  `N_CH`  one-cycle strobe: ongoing pulse just exceeded effective max.
- `pulse_width`  out  `N_CH*CW`  per channel, width of last accepted pulse; channel i at `[i*CW +: CW]`.

## Operation
- Per channel, `act = a[i] ^ polarity[i]`. Sample n is `act` at clock edge n.
- Effective window:
  - `lo = max(min_w, 1)`
  - `hi = min(max_w, MAX_W)`
  - If `lo > hi`, no pulse is ever accepted; edges and `too_long` still operate.
- Per-channel FSM with states UNARMED, ARMED, ACTIVE. Counter `cnt` (`CW` bits) saturates at `MAX_W+1`.
- **UNARMED**, the reset state: act=0 → ARMED; act=1 → stay. No pulse can start before one inactive sample has been seen, so no false detection after reset.
- **ARMED**: act=1 → ACTIVE, cnt=1.
- **ACTIVE**, act=1:
  - `cnt ← min(cnt+1, MAX_W+1)`.
  - If `cnt == hi` before the increment, `too_long` fires (at most once per pulse).
- **ACTIVE**, act=0 → ARMED. If `lo ≤ cnt ≤ hi`: `pulse_detected` fires and `pulse_width ← cnt`. Otherwise the pulse is silently rejected.
- Edge strobes:
  - `rise = act & ~act_prev & prev_valid`
  - `fall = ~act & act_prev & prev_valid`
  - `prev_valid` is cleared by reset and set after the first sample, so the first post-reset sample never produces an edge.
- Polarity change on a channel (registered `polarity` differs from input):
  - That channel goes to UNARMED with cnt=0.
  - No strobes fire on that edge; `prev_valid` is cleared.
  - `pulse_width` holds.
- `min_w`/`max_w` changes take effect on the next edge. A pulse in flight is judged against the window in force at the edge that terminates it.
- Channels are fully independent; simultaneous events on several channels are all reported.

## Timing
- All outputs are registered. Latency is 1 cycle: a strobe caused by sample n is high during the cycle after edge n, for exactly one cycle.
- A pulse of width w occupies samples k..k+w-1:
  - `rise` follows edge k.
  - `fall` and `pulse_detected` follow edge k+w, together.
- `too_long` follows the edge of sample k+hi, i.e. the (hi+1)-th active sample. `fall` still fires at the pulse end.
- Reset, asynchronous while `rst_n`=0:
  - all strobes 0, `pulse_width` 0
  - all FSMs UNARMED, cnt 0, `prev_valid` 0, registered polarity 0
- Reset asserted mid-pulse discards that pulse. After release, a channel held active stays UNARMED until it goes inactive.
- Back-to-back pulses such as "01010" are both detected; the separating inactive sample re-arms.

## Structure
- Package `pulse_det_pkg`: enum `pd_state_t` {UNARMED, ARMED, ACTIVE}, and a function computing the effective window clamp.
- Sub-module `pulse_width_channel`: one channel (FSM, counter, edge registers, width register). The top instantiates `N_CH` copies via generate and computes `lo`/`hi` once.

## Test plan
- Defaults, min_w=max_w=1, ch0 samples 0,1,0 → `rise` after edge 1; `fall` + `pulse_detected` after edge 2; `pulse_width[0]`=1.
- Ch1 held at 1 through and after reset release, then 0 → no `rise`, no `pulse_detected`; `fall` fires at the 1→0 transition (`prev_valid` already set).
- min_w=2, max_w=3, pulses of width 1, 2, 3, 4:
  - only widths 2 and 3 are accepted, with `pulse_width` 2 then 3
  - the width-4 pulse raises `too_long` after its 4th active sample
- max_w=15 (> `MAX_W`=8), 20-cycle pulse → `too_long` once after the 9th active sample; no `pulse_detected`; cnt saturates at 9.
- polarity[2]=1, a[2] samples 1,0,0,1 with window 2..2 → `pulse_detected[2]`, width 2. Then toggle polarity mid-pulse → no strobes, channel re-arms.
- Simultaneous 010 on all 4 channels plus `rst_n` pulsed low mid-pulse on a second burst → first burst all detected; second burst produces no strobes; outputs read 0 during reset.
